// File: rtl/sm3_pkg.sv
// Shared SM3 padding types and constants.
package sm3_pkg;
    typedef enum logic [1:0] {
        S_MSG  = 2'd0,
        S_P80  = 2'd1,
        S_ZERO = 2'd2,
        S_LEN  = 2'd3
    } pad_state_e;

    localparam int         SM3_BLK_BITS = 512;
    localparam int         SM3_LEN_BITS = 64;
    localparam logic [7:0] SM3_MARKER   = 8'h80;
endpackage

// File: rtl/sm3_pad_byte_ins.sv
// Beat cleanup: zero invalid bytes, optionally drop the 0x80 marker into the
// first invalid byte, and count valid bytes.
module sm3_pad_byte_ins
    import sm3_pkg::*;
#(
    parameter int INPT_DW = 32
) (
    input  logic [INPT_DW-1:0]         d,
    input  logic [INPT_DW/8-1:0]       vld_byte,
    input  logic                       ins_en,
    output logic [INPT_DW-1:0]         d_pad,
    output logic [$clog2(INPT_DW/8):0] pop
);
    localparam int NB   = INPT_DW / 8;
    localparam int PC_W = $clog2(NB) + 1;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NB; i++) pop = pop + PC_W'(vld_byte[i]);
        d_pad = '0;
        // byte i = 0 is the first byte on the wire; with a contiguous mask the
        // first free byte sits at index pop
        for (int i = 0; i < NB; i++) begin
            if (vld_byte[NB-1-i])
                d_pad[INPT_DW-1-8*i -: 8] = d[INPT_DW-1-8*i -: 8];
            else if (ins_en && (pop == PC_W'(i)))
                d_pad[INPT_DW-1-8*i -: 8] = SM3_MARKER;
        end
    end
endmodule

// File: rtl/sm3_msg_padder.sv
// SM3 message padder: message beats in, padded 512-bit blocks out as words.
// Optional protocol checker enabled with SM3_PAD_ERR_EN.
module sm3_msg_padder
    import sm3_pkg::*;
#(
    parameter int INPT_DW = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INPT_DW-1:0]    msg_inpt_d,
    input  logic [INPT_DW/8-1:0]  msg_inpt_vld_byte,
    input  logic                  msg_inpt_vld,
    input  logic                  msg_inpt_lst,
    output logic                  msg_inpt_rdy,
    output logic [INPT_DW-1:0]    pad_otpt_d,
    output logic                  pad_otpt_vld,
    input  logic                  pad_otpt_rdy,
    output logic                  pad_otpt_lst,
    output logic                  pad_otpt_msg_lst,
    output logic                  pad_err
);
    localparam int BLK_WORDS = SM3_BLK_BITS / INPT_DW;
    localparam int NB        = INPT_DW / 8;
    localparam int PC_W      = $clog2(NB) + 1;
    localparam int WCNT_W    = $clog2(BLK_WORDS);
    localparam int LEN_WORDS = SM3_LEN_BITS / INPT_DW;
    localparam int LEN_IDX   = BLK_WORDS - LEN_WORDS;

    pad_state_e          state, state_nxt, after_pad;
    logic [WCNT_W-1:0]   wcnt, wnext;
    logic [60:0]         bytecnt;
    logic [63:0]         len_bits;
    logic [INPT_DW-1:0]  len_word, beat_pad, load_d;
    logic [PC_W-1:0]     pop;
    logic                rdy_en, adv, acc, mask_full, load, load_mlst;
    logic [INPT_DW-1:0]  d_p0;
    logic                vld_p0, lst_p0, msg_lst_p0;

    sm3_pad_byte_ins #(.INPT_DW(INPT_DW)) u_byte_ins (
        .d        (msg_inpt_d),
        .vld_byte (msg_inpt_vld_byte),
        .ins_en   (msg_inpt_lst),
        .d_pad    (beat_pad),
        .pop      (pop)
    );

    assign adv          = !vld_p0 | pad_otpt_rdy;
    assign msg_inpt_rdy = rdy_en & (state == S_MSG) & adv;
    assign acc          = msg_inpt_vld & msg_inpt_rdy;
    assign mask_full    = &msg_inpt_vld_byte;
    assign wnext        = wcnt + WCNT_W'(1);
    // padding after the marker heads for the length slot, crossing a block if needed
    assign after_pad    = (wnext == WCNT_W'(LEN_IDX)) ? S_LEN : S_ZERO;
    assign len_bits     = {bytecnt, 3'b000};
    assign len_word     = (wcnt == WCNT_W'(BLK_WORDS-1)) ? len_bits[INPT_DW-1:0]
                                                         : len_bits[SM3_LEN_BITS-1 -: INPT_DW];

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_d    = '0;
        load_mlst = 1'b0;
        case (state)
            S_MSG: if (acc) begin
                load   = 1'b1;
                load_d = beat_pad;
                if (msg_inpt_lst) state_nxt = mask_full ? S_P80 : after_pad;
            end
            S_P80: if (adv) begin
                load      = 1'b1;
                load_d    = {SM3_MARKER, {(INPT_DW-8){1'b0}}};
                state_nxt = after_pad;
            end
            S_ZERO: if (adv) begin
                load      = 1'b1;
                state_nxt = after_pad;
            end
            S_LEN: if (adv) begin
                load   = 1'b1;
                load_d = len_word;
                if (wcnt == WCNT_W'(BLK_WORDS-1)) begin
                    load_mlst = 1'b1;
                    state_nxt = S_MSG;
                end
            end
            default: state_nxt = S_MSG;
        endcase
    end

    // output register stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_MSG;
            rdy_en     <= 1'b0;
            wcnt       <= '0;
            bytecnt    <= '0;
            d_p0       <= '0;
            vld_p0     <= 1'b0;
            lst_p0     <= 1'b0;
            msg_lst_p0 <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
            if (load) begin
                d_p0       <= load_d;
                vld_p0     <= 1'b1;
                lst_p0     <= (wcnt == WCNT_W'(BLK_WORDS-1));
                msg_lst_p0 <= load_mlst;
                wcnt       <= wnext;
            end else if (pad_otpt_rdy) begin
                vld_p0     <= 1'b0;
                lst_p0     <= 1'b0;
                msg_lst_p0 <= 1'b0;
            end
            if (acc)            bytecnt <= bytecnt + 61'(pop);
            else if (load_mlst) bytecnt <= '0;
        end
    end

    assign pad_otpt_d       = d_p0;
    assign pad_otpt_vld     = vld_p0;
    assign pad_otpt_lst     = lst_p0;
    assign pad_otpt_msg_lst = msg_lst_p0;

`ifdef SM3_PAD_ERR_EN
    logic [NB-1:0] inv_mask;
    logic [61:0]   cnt_sum;
    logic          err_det, err_q;

    assign inv_mask = ~msg_inpt_vld_byte;
    assign cnt_sum  = {1'b0, bytecnt} + 62'(pop);
    // a legal mask inverted is a run of ones from the LSB, so adding one clears it
    assign err_det  = ((inv_mask & (inv_mask + NB'(1))) != '0)
                    | (!msg_inpt_lst & !mask_full)
                    | cnt_sum[61];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                err_q <= 1'b0;
        else if (acc & err_det) err_q <= 1'b1;
    end
    assign pad_err = err_q;
`else
    assign pad_err = 1'b0;
`endif
endmodule

// File: tb/tb_sm3_msg_padder.sv
// Randomised bench for sm3_msg_padder at 32- and 64-bit beat widths against a
// byte-level SM3 padding model.
module tb_sm3_msg_padder;
`ifdef SM3_PAD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk, rst;
    logic [31:0] m32_d;  logic [3:0] m32_vb; logic m32_vld, m32_lst, m32_rdy;
    logic [31:0] o32_d;  logic o32_vld, o32_rdy, o32_lst, o32_mlst, e32;
    logic [63:0] m64_d;  logic [7:0] m64_vb; logic m64_vld, m64_lst, m64_rdy;
    logic [63:0] o64_d;  logic o64_vld, o64_rdy, o64_lst, o64_mlst, e64;

    int n_chk = 0;
    int n_err = 0;
    bit stall_en = 0;
    bit done_f = 0;
    logic [7:0]  tx_q[$];
    logic [63:0] od_q[$], exp_d[$], ref_q[$];
    bit          ol_q[$], om_q[$], exp_l[$], exp_m[$];

    sm3_msg_padder #(.INPT_DW(32)) u32 (
        .clk(clk), .rst(rst),
        .msg_inpt_d(m32_d), .msg_inpt_vld_byte(m32_vb), .msg_inpt_vld(m32_vld),
        .msg_inpt_lst(m32_lst), .msg_inpt_rdy(m32_rdy),
        .pad_otpt_d(o32_d), .pad_otpt_vld(o32_vld), .pad_otpt_rdy(o32_rdy),
        .pad_otpt_lst(o32_lst), .pad_otpt_msg_lst(o32_mlst), .pad_err(e32)
    );

    sm3_msg_padder #(.INPT_DW(64)) u64 (
        .clk(clk), .rst(rst),
        .msg_inpt_d(m64_d), .msg_inpt_vld_byte(m64_vb), .msg_inpt_vld(m64_vld),
        .msg_inpt_lst(m64_lst), .msg_inpt_rdy(m64_rdy),
        .pad_otpt_d(o64_d), .pad_otpt_vld(o64_vld), .pad_otpt_rdy(o64_rdy),
        .pad_otpt_lst(o64_lst), .pad_otpt_msg_lst(o64_mlst), .pad_err(e64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            o32_rdy = stall_en ? ($urandom % 3 != 0) : 1'b1;
            o64_rdy = stall_en ? ($urandom % 3 != 0) : 1'b1;
        end
    end

    initial begin : mon32
        bit hold;
        logic [31:0] hd;
        hold = 1'b0;
        hd = '0;
        forever begin
            @(negedge clk);
            if (rst) hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold_vld32", 64'(o32_vld), 64'd1);
                    chk("hold_d32", 64'(o32_d), 64'(hd));
                end
                if (o32_vld && o32_rdy) begin
                    od_q.push_back(64'(o32_d)); ol_q.push_back(o32_lst); om_q.push_back(o32_mlst);
                    if (o32_mlst) done_f = 1'b1;
                end
                hold = o32_vld && !o32_rdy;
                hd = o32_d;
            end
        end
    end

    initial begin : mon64
        bit hold;
        logic [63:0] hd;
        hold = 1'b0;
        hd = '0;
        forever begin
            @(negedge clk);
            if (rst) hold = 1'b0;
            else begin
                if (hold) begin
                    chk("hold_vld64", 64'(o64_vld), 64'd1);
                    chk("hold_d64", o64_d, hd);
                end
                if (o64_vld && o64_rdy) begin
                    od_q.push_back(o64_d); ol_q.push_back(o64_lst); om_q.push_back(o64_mlst);
                    if (o64_mlst) done_f = 1'b1;
                end
                hold = o64_vld && !o64_rdy;
                hd = o64_d;
            end
        end
    end

    // Reference: bytes, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length.
    task automatic build_exp(input int dw);
        logic [7:0]  p[$];
        logic [63:0] bitlen, w;
        int nb, bw, nw;
        p = tx_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitlen = 64'(tx_q.size()) * 64'd8;
        for (int j = 0; j < 8; j++) p.push_back(bitlen[63-8*j -: 8]);
        nb = dw / 8;
        bw = 512 / dw;
        nw = p.size() / nb;
        exp_d.delete(); exp_l.delete(); exp_m.delete();
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int j = 0; j < nb; j++) w = (w << 8) | 64'(p[i*nb+j]);
            exp_d.push_back(w);
            exp_l.push_back((i + 1) % bw == 0);
            exp_m.push_back(i == nw - 1);
        end
    endtask

    task automatic drive_beat(input int dw, input logic [63:0] d, input logic [7:0] vb, input bit lst);
        int cyc;
        bit ok;
        if (dw == 32) begin
            m32_d = d[31:0]; m32_vb = vb[3:0]; m32_lst = lst; m32_vld = 1'b1;
        end else begin
            m64_d = d; m64_vb = vb; m64_lst = lst; m64_vld = 1'b1;
        end
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            ok = (dw == 32) ? m32_rdy : m64_rdy;
        end while (!ok && cyc < 200);
        chk("beat_accept", 64'(ok), 64'd1);
        @(posedge clk);
        #1;
        m32_vld = 1'b0; m32_lst = 1'b0;
        m64_vld = 1'b0; m64_lst = 1'b0;
    endtask

    task automatic run_msg(input int dw, input bit stall, input bit extra_in);
        int nb, n, i, k, cyc;
        logic [63:0] d;
        logic [7:0] vb;
        bit extra;
        nb = dw / 8;
        n = tx_q.size();
        extra = extra_in && (n > 0) && (n % nb == 0);
        build_exp(dw);
        od_q.delete(); ol_q.delete(); om_q.delete();
        done_f = 1'b0;
        stall_en = stall;
        @(posedge clk);
        #1;
        if (n == 0) drive_beat(dw, {$urandom, $urandom}, 8'h00, 1'b1);
        i = 0;
        while (i < n) begin
            k = (n - i < nb) ? n - i : nb;
            d = {$urandom, $urandom};
            vb = '0;
            for (int j = 0; j < k; j++) begin
                d[dw-1-8*j -: 8] = tx_q[i+j];
                vb[nb-1-j] = 1'b1;
            end
            i += k;
            drive_beat(dw, d, vb, (i == n) && !extra);
        end
        if (extra) drive_beat(dw, {$urandom, $urandom}, 8'h00, 1'b1);
        cyc = 0;
        while (!done_f && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk("msg_done", 64'(done_f), 64'd1);
        repeat (4) @(negedge clk);
        stall_en = 1'b0;
        chk("nwords", 64'(od_q.size()), 64'(exp_d.size()));
        for (int w = 0; w < od_q.size() && w < exp_d.size(); w++) begin
            chk($sformatf("word%0d", w), od_q[w], exp_d[w]);
            chk($sformatf("lst%0d", w), 64'(ol_q[w]), 64'(exp_l[w]));
            chk($sformatf("msglst%0d", w), 64'(om_q[w]), 64'(exp_m[w]));
        end
    endtask

    function automatic int count_lst();
        int c;
        c = 0;
        foreach (ol_q[i]) c += int'(ol_q[i]);
        return c;
    endfunction

    task automatic rand_bytes(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    initial begin
        logic [63:0] t;
        rst = 1'b1;
        m32_d = '0; m32_vb = '0; m32_vld = 1'b0; m32_lst = 1'b0; o32_rdy = 1'b1;
        m64_d = '0; m64_vb = '0; m64_vld = 1'b0; m64_lst = 1'b0; o64_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_vld32", 64'(o32_vld), 64'd0);
        chk("rst_d32", 64'(o32_d), 64'd0);
        chk("rst_lst32", 64'({o32_lst, o32_mlst}), 64'd0);
        chk("rst_rdy32", 64'(m32_rdy), 64'd0);
        chk("rst_vld64", 64'(o64_vld), 64'd0);
        chk("rst_d64", o64_d, 64'd0);
        chk("rst_rdy64", 64'(m64_rdy), 64'd0);
        chk("rst_err", 64'({e32, e64}), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rdy_after_rst32", 64'(m32_rdy), 64'd1);
        chk("rdy_after_rst64", 64'(m64_rdy), 64'd1);

        tx_q = '{8'h61, 8'h62, 8'h63};
        run_msg(32, 1'b0, 1'b0);
        chk("abc_w0", od_q[0], 64'h61626380);
        chk("abc_w15", od_q[15], 64'h18);

        rand_bytes(56);
        run_msg(32, 1'b0, 1'b0);
        chk("b56_w14", od_q[14], 64'h80000000);
        chk("b56_w31", od_q[31], 64'h1C0);
        chk("b56_blocks", 64'(count_lst()), 64'd2);

        rand_bytes(55);
        run_msg(32, 1'b0, 1'b0);
        t = od_q[13];
        chk("b55_w13_lo", 64'(t[7:0]), 64'h80);
        chk("b55_w15", od_q[15], 64'h1B8);
        chk("b55_blocks", 64'(count_lst()), 64'd1);

        tx_q.delete();
        run_msg(64, 1'b0, 1'b0);
        chk("empty_w0", od_q[0], 64'h8000000000000000);
        chk("empty_w7", od_q[7], 64'h0);

        rand_bytes(64);
        run_msg(32, 1'b0, 1'b0);
        ref_q = od_q;
        run_msg(32, 1'b1, 1'b0);
        chk("stall_len", od_q[31], 64'h200);
        chk("stall_blocks", 64'(count_lst()), 64'd2);
        chk("stall_nwords", 64'(od_q.size()), 64'(ref_q.size()));
        for (int i = 0; i < ref_q.size() && i < od_q.size(); i++)
            chk($sformatf("stall_eq%0d", i), od_q[i], ref_q[i]);

        for (int r = 0; r < 8; r++) begin
            rand_bytes($urandom_range(0, 140));
            run_msg(($urandom % 2) ? 64 : 32, 1'($urandom % 2), 1'($urandom % 2));
        end
        rand_bytes(128);
        run_msg(64, 1'b1, 1'b1);

        // abort in the middle of a block
        @(posedge clk);
        #1;
        for (int b = 0; b < 3; b++) drive_beat(64, {$urandom, $urandom}, 8'hFF, 1'b0);
        rst = 1'b1;
        #1;
        chk("abort_vld", 64'(o64_vld), 64'd0);
        chk("abort_d", o64_d, 64'd0);
        chk("abort_flags", 64'({o64_lst, o64_mlst}), 64'd0);
        chk("abort_rdy", 64'(m64_rdy), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_bytes(20);
        run_msg(64, 1'b0, 1'b0);

        // malformed mask on a non-last beat
        @(posedge clk);
        #1;
        drive_beat(32, {$urandom, $urandom}, 8'h0B, 1'b0);
        @(negedge clk);
        chk("err_set", 64'(e32), 64'(ERR_EN));
        repeat (5) @(negedge clk);
        chk("err_sticky", 64'(e32), 64'(ERR_EN));
        rst = 1'b1;
        #1;
        chk("err_clr", 64'(e32), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_bytes(9);
        run_msg(32, 1'b1, 1'b0);
        chk("err_clean", 64'(e32), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
